// File: rtl/hmm_pkg.sv
// ----------------------------------------------------------------------------
// hmm_pkg: shared constants, types and fixed-point multiply for the beta engine.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hmm_pkg;

  localparam int HIDDEN_STATES   = 2;
  localparam int OBSERVED_STATES = 2;
  localparam int OBSERVED_LEN    = 3;
  localparam int DATA_PREC       = 8;

  localparam int H_W   = (HIDDEN_STATES > 1) ? $clog2(HIDDEN_STATES) : 1;
  localparam int OBS_W = (OBSERVED_STATES > 1) ? $clog2(OBSERVED_STATES) : 1;
  localparam int T_W   = (OBSERVED_LEN > 1) ? $clog2(OBSERVED_LEN) : 1;

  typedef logic [DATA_PREC-1:0] prob_t;
  typedef logic [OBS_W-1:0]     obs_t;
  typedef logic [H_W-1:0]       hidx_t;
  typedef logic [T_W-1:0]       tidx_t;

  typedef prob_t [HIDDEN_STATES-1:0][HIDDEN_STATES-1:0]   trans_t;
  typedef prob_t [HIDDEN_STATES-1:0][OBSERVED_STATES-1:0] emm_t;
  typedef obs_t  [OBSERVED_LEN-1:0]                       obs_seq_t;

  localparam prob_t PROB_ONE = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_MAC  = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } beta_state_t;

  // Q0.DATA_PREC product, truncated back to DATA_PREC bits
  function automatic prob_t mul_q(input prob_t a, input prob_t b);
    logic [2*DATA_PREC-1:0] p;
    p = {{DATA_PREC{1'b0}}, a} * {{DATA_PREC{1'b0}}, b};
    return prob_t'(p >> DATA_PREC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hmm_beta_engine_if.sv
// ----------------------------------------------------------------------------
// hmm_beta_engine_if: control, model inputs and beta stream of the beta engine.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hmm_beta_engine_if;
  import hmm_pkg::*;

  logic     start;
  obs_seq_t observed_seq;
  trans_t   trans;
  emm_t     emm;
  logic     busy;
  logic     done;
  logic     beta_valid;
  logic     beta_ready;
  tidx_t    beta_t;
  hidx_t    beta_i;
  prob_t    beta_data;

  modport master (
    input  start, observed_seq, trans, emm, beta_ready,
    output busy, done, beta_valid, beta_t, beta_i, beta_data
  );

  modport slave (
    output start, observed_seq, trans, emm, beta_ready,
    input  busy, done, beta_valid, beta_t, beta_i, beta_data
  );

endinterface

`default_nettype wire

// File: rtl/hmm_mac.sv
// ----------------------------------------------------------------------------
// hmm_mac: accumulates trans*emm*beta_next; HMM_BETA_SAT_EN makes the add saturate.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hmm_mac
  import hmm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  input  prob_t trans_val,
  input  prob_t emm_val,
  input  prob_t beta_val,
  output prob_t acc
);

  prob_t term;
  prob_t base;
  prob_t acc_nxt;
`ifdef HMM_BETA_SAT_EN
  logic [DATA_PREC:0] sum;
`endif

  always_comb begin
    term = mul_q(mul_q(trans_val, emm_val), beta_val);
    base = clr ? '0 : acc;
`ifdef HMM_BETA_SAT_EN
    sum     = {1'b0, base} + {1'b0, term};
    acc_nxt = sum[DATA_PREC] ? PROB_ONE : sum[DATA_PREC-1:0];
`else
    acc_nxt = base + term;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hmm_beta_engine.sv
// ----------------------------------------------------------------------------
// hmm_beta_engine: sequential HMM backward pass, betas streamed t descending.
// Rev 1.0 -- accumulation mode follows HMM_BETA_SAT_EN (see hmm_mac).
// ----------------------------------------------------------------------------
`default_nettype none

module hmm_beta_engine
  import hmm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  hmm_beta_engine_if.master bus
);

  localparam hidx_t H_LAST = hidx_t'(HIDDEN_STATES - 1);
  localparam tidx_t T_LAST = tidx_t'(OBSERVED_LEN - 1);

  beta_state_t state;
  beta_state_t state_nxt;
  tidx_t       t_cnt;
  hidx_t       i_cnt;
  hidx_t       j_cnt;
  logic        sel;
  prob_t       layer_buf [2][HIDDEN_STATES];
  prob_t       acc;
  obs_t        obs_next;
  logic        valid;
  logic        hs;
  logic        last_i;
  logic        last_j;
  logic        last_t;

  assign valid    = (state == S_INIT) || (state == S_EMIT);
  assign hs       = valid && bus.beta_ready;
  assign last_i   = (i_cnt == H_LAST);
  assign last_j   = (j_cnt == H_LAST);
  assign last_t   = (t_cnt == '0);
  assign obs_next = bus.observed_seq[t_cnt + tidx_t'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_INIT;
      S_INIT: if (hs && last_i) state_nxt = (OBSERVED_LEN > 1) ? S_MAC : S_DONE;
      S_MAC:  if (last_j) state_nxt = S_EMIT;
      S_EMIT: if (hs) state_nxt = (last_i && last_t) ? S_DONE : S_MAC;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // layer_buf[sel] holds beta_{t+1}; the layer being produced goes to layer_buf[~sel]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_cnt     <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      sel       <= 1'b0;
      layer_buf <= '{default: '0};
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            t_cnt <= T_LAST;
            i_cnt <= '0;
            j_cnt <= '0;
          end
        end
        S_INIT: begin
          if (hs) begin
            layer_buf[~sel][i_cnt] <= PROB_ONE;
            if (last_i) begin
              i_cnt <= '0;
              sel   <= ~sel;
              if (!last_t) t_cnt <= t_cnt - tidx_t'(1);
            end else begin
              i_cnt <= i_cnt + hidx_t'(1);
            end
          end
        end
        S_MAC: begin
          j_cnt <= last_j ? '0 : j_cnt + hidx_t'(1);
        end
        S_EMIT: begin
          if (hs) begin
            layer_buf[~sel][i_cnt] <= acc;
            if (last_i) begin
              i_cnt <= '0;
              if (!last_t) begin
                sel   <= ~sel;
                t_cnt <= t_cnt - tidx_t'(1);
              end
            end else begin
              i_cnt <= i_cnt + hidx_t'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  hmm_mac u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       ((state == S_MAC) && (j_cnt == '0)),
    .en        (state == S_MAC),
    .trans_val (bus.trans[i_cnt][j_cnt]),
    .emm_val   (bus.emm[j_cnt][obs_next]),
    .beta_val  (layer_buf[sel][j_cnt]),
    .acc       (acc)
  );

  assign bus.busy       = (state == S_INIT) || (state == S_MAC) || (state == S_EMIT);
  assign bus.done       = (state == S_DONE);
  assign bus.beta_valid = valid;
  assign bus.beta_t     = t_cnt;
  assign bus.beta_i     = i_cnt;
  assign bus.beta_data  = (state == S_INIT) ? PROB_ONE : acc;

endmodule

`default_nettype wire

// File: tb/tb_hmm_beta_engine.sv
// ----------------------------------------------------------------------------
// tb_hmm_beta_engine: table vectors, corner sequences and random runs vs a model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hmm_beta_engine;
  import hmm_pkg::*;

  localparam int H        = HIDDEN_STATES;
  localparam int OS       = OBSERVED_STATES;
  localparam int T        = OBSERVED_LEN;
  localparam int DP       = DATA_PREC;
  localparam int MAXV     = (1 << DP) - 1;
  localparam int BASE_LAT = H + (T - 1) * H * (H + 1) + 1;
`ifdef HMM_BETA_SAT_EN
  localparam int FF_B1 = 'hFF;
  localparam int FF_B0 = 'hFF;
`else
  localparam int FF_B1 = 'hFA;
  localparam int FF_B0 = 'hF0;
`endif

  typedef struct {int t; int i; int d;} beat_t;
  typedef struct {int tr_v; int em_v; int b1; int b0;} vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hmm_beta_engine_if bus ();

  hmm_beta_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t exp_q[$];
  int    tr [H][H];
  int    em [H][OS];
  int    ob [T];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < H; j++)
        bus.trans[hidx_t'(i)][hidx_t'(j)] = prob_t'(tr[i][j]);
    for (int j = 0; j < H; j++)
      for (int o = 0; o < OS; o++)
        bus.emm[hidx_t'(j)][obs_t'(o)] = prob_t'(em[j][o]);
    for (int t = 0; t < T; t++)
      bus.observed_seq[tidx_t'(t)] = obs_t'(ob[t]);
  endtask

  task automatic set_uniform(input int tv, input int ev);
    for (int i = 0; i < H; i++) for (int j = 0; j < H; j++) tr[i][j] = tv;
    for (int j = 0; j < H; j++) for (int o = 0; o < OS; o++) em[j][o] = ev;
    for (int t = 0; t < T; t++) ob[t] = $urandom_range(0, OS - 1);
    apply_inputs();
  endtask

  // Expected stream straight from a table row (three layers, identical across i)
  task automatic fill_from_vec(input vec_t v);
    exp_q.delete();
    for (int i = 0; i < H; i++) exp_q.push_back('{2, i, MAXV});
    for (int i = 0; i < H; i++) exp_q.push_back('{1, i, v.b1});
    for (int i = 0; i < H; i++) exp_q.push_back('{0, i, v.b0});
  endtask

  // Reference backward recursion over plain integer arrays
  task automatic model();
    int bn [H];
    int bc [H];
    exp_q.delete();
    for (int i = 0; i < H; i++) begin
      bn[i] = MAXV;
      exp_q.push_back('{T - 1, i, MAXV});
    end
    for (int t = T - 2; t >= 0; t--) begin
      for (int i = 0; i < H; i++) begin
        int a = 0;
        for (int j = 0; j < H; j++) begin
          int p;
          p = (tr[i][j] * em[j][ob[t + 1]]) >> DP;
          p = (p * bn[j]) >> DP;
          a = a + p;
`ifdef HMM_BETA_SAT_EN
          if (a > MAXV) a = MAXV;
`else
          a = a & MAXV;
`endif
        end
        bc[i] = a;
        exp_q.push_back('{t, i, a});
      end
      bn = bc;
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: 5-cycle stall at first MAC-layer beta
  task automatic run(input string nm, input int mode, input int restart_at, input int reset_at);
    int    cyc = 0, stalls = 0, got = 0, stall_left = 5;
    int    sv_t = 0, sv_i = 0, sv_d = 0;
    bit    done_seen = 0, prev_stall = 0;
    logic  r;
    beat_t e;
    bus.beta_ready = 1'b1;
    bus.start      = 1'b1;
    @(posedge clk);
    while (!done_seen && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk({nm, " busy after reset"}, int'(bus.busy), 0);
        chk({nm, " valid after reset"}, int'(bus.beta_valid), 0);
        chk({nm, " done after reset"}, int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      bus.start = (cyc == restart_at);
      chk({nm, " busy"}, int'(bus.busy), int'(!bus.done));
      if (prev_stall) begin
        chk({nm, " valid held"}, int'(bus.beta_valid), 1);
        chk({nm, " t held"}, int'(bus.beta_t), sv_t);
        chk({nm, " i held"}, int'(bus.beta_i), sv_i);
        chk({nm, " data held"}, int'(bus.beta_data), sv_d);
      end
      if (bus.done) begin
        done_seen = 1;
        chk({nm, " done cycle"}, cyc, BASE_LAT + stalls);
        chk({nm, " beta count"}, got, H * T);
      end
      case (mode)
        1:       r = 1'($urandom_range(0, 1));
        2: begin
          r = 1'b1;
          if (bus.beta_valid && int'(bus.beta_t) == T - 2 && bus.beta_i == '0 && stall_left > 0) begin
            r = 1'b0;
            stall_left--;
          end
        end
        default: r = 1'b1;
      endcase
      bus.beta_ready = r;
      prev_stall = 0;
      if (bus.beta_valid && r) begin
        got++;
        if (exp_q.size() == 0) begin
          chk({nm, " extra beta"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({nm, " beta_t"}, int'(bus.beta_t), e.t);
          chk({nm, " beta_i"}, int'(bus.beta_i), e.i);
          chk({nm, " beta_data"}, int'(bus.beta_data), e.d);
        end
      end else if (bus.beta_valid) begin
        stalls++;
        prev_stall = 1;
        sv_t = int'(bus.beta_t);
        sv_i = int'(bus.beta_i);
        sv_d = int'(bus.beta_data);
      end
    end
    bus.start = 1'b0;
    if (!done_seen) begin
      chk({nm, " done timeout"}, 0, 1);
      return;
    end
    chk({nm, " betas missing"}, exp_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({nm, " done pulse width"}, int'(bus.done), 0);
      chk({nm, " idle busy"}, int'(bus.busy), 0);
      chk({nm, " idle valid"}, int'(bus.beta_valid), 0);
    end
  endtask

  initial begin
    vec_t tbl [4];
    vec_t uni;
    tbl[0] = '{'h80, 'h80, 'h7E, 'h3E};
    tbl[1] = '{'hFF, 'hFF, FF_B1, FF_B0};
    tbl[2] = '{'h00, 'h00, 'h00, 'h00};
    tbl[3] = '{'h40, 'hC0, 'h5E, 'h22};
    uni    = tbl[0];

    bus.start      = 1'b0;
    bus.beta_ready = 1'b1;
    set_uniform(0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset valid", int'(bus.beta_valid), 0);
    chk("reset beta_t", int'(bus.beta_t), 0);
    chk("reset beta_i", int'(bus.beta_i), 0);
    chk("reset beta_data", int'(bus.beta_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      set_uniform(tbl[k].tr_v, tbl[k].em_v);
      fill_from_vec(tbl[k]);
      run($sformatf("table%0d", k), 0, 0, 0);
    end

    set_uniform(uni.tr_v, uni.em_v);
    fill_from_vec(uni);
    run("backpressure", 2, 0, 0);

    fill_from_vec(uni);
    run("start_busy", 0, 6, 0);

    fill_from_vec(uni);
    run("reset_mid", 0, 0, 4);
    fill_from_vec(uni);
    run("after_reset", 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < H; i++) for (int j = 0; j < H; j++) tr[i][j] = $urandom_range(0, MAXV);
      for (int j = 0; j < H; j++) for (int o = 0; o < OS; o++) em[j][o] = $urandom_range(0, MAXV);
      for (int t = 0; t < T; t++) ob[t] = $urandom_range(0, OS - 1);
      apply_inputs();
      model();
      run($sformatf("random%0d", n), 1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
